// File: rtl/indirect_sync_ram.sv
// Single-port synchronous RAM with a valid/ready request channel and a registered response pulse.
// Indirect requests first fetch a little-endian pointer from memory, then access the word it points at.
module indirect_sync_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 13,
    parameter int DEPTH      = 8192
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic                  req_indirect,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int PTR_WORDS = (ADDR_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W     = (PTR_WORDS > 1) ? $clog2(PTR_WORDS + 1) : 1;
    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable in the range compare.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PTR    = 2'd1,
        ACCESS = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    state_t                state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [ADDR_WIDTH-1:0] acc_addr_s;
    logic                  acc_we_s;
    logic [DATA_WIDTH-1:0] acc_wdata_s;
    logic                  acc_oob_s;
    logic                  acc_en_s;
    logic                  mem_we_s;
    logic [ADDR_WIDTH:0]   sum_s;
    logic [IDX_W-1:0]      fetch_idx_s;
    logic [IDX_W-1:0]      mem_idx_s;
    logic [DATA_WIDTH-1:0] rd_word_s;

    // Select the access source: live request in IDLE, latched request and pointer in ACCESS.
    always_comb begin
        acc_addr_s  = (state_q == ACCESS) ? ptr_q   : req_addr;
        acc_we_s    = (state_q == ACCESS) ? we_q    : req_we;
        acc_wdata_s = (state_q == ACCESS) ? wdata_q : req_wdata;
        acc_oob_s   = ({1'b0, acc_addr_s} >= DEPTH_W);
        acc_en_s    = (state_q == ACCESS) ||
                      ((state_q == IDLE) && req_valid && !req_indirect);
        mem_we_s    = rst_n && acc_en_s && acc_we_s && !acc_oob_s;
        sum_s       = {1'b0, base_q} + (ADDR_WIDTH + 1)'(cnt_q);
        fetch_idx_s = IDX_W'(sum_s % DEPTH_W);
        mem_idx_s   = (state_q == PTR) ? fetch_idx_s : IDX_W'(acc_addr_s);
    end

    assign rd_word_s = mem[mem_idx_s];

    // Memory array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_idx_s] <= acc_wdata_s;
        end
    end

    // Next-state and next-output logic for the request FSM.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_indirect) begin
                    state_d = PTR;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    base_d  = req_addr;
                    cnt_d   = '0;
                    ptr_d   = '0;
                end else if (req_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = acc_oob_s;
                    rsp_rdata_d = (acc_oob_s || req_we) ? '0 : rd_word_s;
                end else begin
                    state_d = IDLE;
                end
            end
            PTR: begin
                // Pointer bits beyond ADDR_WIDTH in the last fetched word are simply dropped.
                for (int b = 0; b < ADDR_WIDTH; b++) begin
                    if ((b / DATA_WIDTH) == int'(cnt_q)) begin
                        ptr_d[b] = rd_word_s[b % DATA_WIDTH];
                    end else begin
                        ptr_d[b] = ptr_q[b];
                    end
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(PTR_WORDS - 1)) begin
                    state_d = ACCESS;
                end else begin
                    state_d = PTR;
                end
            end
            ACCESS: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = acc_oob_s;
                rsp_rdata_d = (acc_oob_s || we_q) ? '0 : rd_word_s;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    // State and registered outputs; async reset abandons any in-flight indirect access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            base_q      <= '0;
            cnt_q       <= '0;
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_indirect_sync_ram.sv
// Scoreboard bench for indirect_sync_ram: one full-depth instance and one DEPTH=4096 instance.
module tb_indirect_sync_ram;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic        req_indirect = 1'b0;
    logic [12:0] req_addr = 13'd0;
    logic [7:0]  req_wdata = 8'd0;
    logic        sel = 1'b0;

    logic        vld_a, vld_b, rdy_a, rdy_b, rdy_s;
    logic        rv_a, rv_b, err_a, err_b;
    logic [7:0]  rd_a, rd_b;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t       q_a[$];
    exp_t       q_b[$];
    logic [7:0] mdl_a [0:8191];
    logic [7:0] mdl_b [0:4095];
    int         cyc = 0;
    int         n_assert = 0;
    int         n_fail = 0;

    assign vld_a = req_valid & ~sel;
    assign vld_b = req_valid & sel;
    assign rdy_s = sel ? rdy_b : rdy_a;

    indirect_sync_ram dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(vld_a), .req_ready(rdy_a),
        .req_we(req_we), .req_indirect(req_indirect), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_err(err_a)
    );

    indirect_sync_ram #(.DEPTH(4096)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(vld_b), .req_ready(rdy_b),
        .req_we(req_we), .req_indirect(req_indirect), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_err(err_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] mrd(input logic s, input int a);
        return s ? mdl_b[a] : mdl_a[a];
    endfunction

    // Response monitors: every pulse must match the oldest expectation, including its cycle.
    always @(negedge clk) begin
        if (rv_a) begin
            if (q_a.size() == 0) begin
                check_val("spurious_rsp_a", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check_val("rdata_a", rd_a, e.rdata);
                check_val("err_a", err_a, e.err);
                check_val("latency_a", cyc, e.cyc);
            end
        end
        if (rv_b) begin
            if (q_b.size() == 0) begin
                check_val("spurious_rsp_b", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check_val("rdata_b", rd_b, e.rdata);
                check_val("err_b", err_b, e.err);
                check_val("latency_b", cyc, e.cyc);
            end
        end
    end

    // Drive one request (entered just after a rising edge), update the model, push the expectation.
    task automatic send(input logic we, input logic ind, input logic [12:0] addr, input logic [7:0] wd);
        exp_t        e;
        int          waited;
        int          depth;
        int          a;
        int          eff;
        logic [15:0] p;
        req_we       = we;
        req_indirect = ind;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        waited       = 0;
        while (!rdy_s && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check_val("accept_wait", waited, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        depth = sel ? 4096 : 8192;
        a     = int'(addr);
        if (ind) begin
            p   = {mrd(sel, (a + 1) % depth), mrd(sel, a % depth)};
            eff = int'(p[12:0]);
        end else begin
            eff = a;
        end
        e.cyc = cyc + (ind ? 3 : 0);
        if (eff >= depth) begin
            e.rdata = 8'd0;
            e.err   = 1'b1;
        end else if (we) begin
            if (sel) mdl_b[eff] = wd;
            else     mdl_a[eff] = wd;
            e.rdata = 8'd0;
            e.err   = 1'b0;
        end else begin
            e.rdata = mrd(sel, eff);
            e.err   = 1'b0;
        end
        if (sel) q_b.push_back(e);
        else     q_a.push_back(e);
        if (ind) begin
            for (int i = 0; i < 3; i++) begin
                check_val("busy_ready", rdy_s, 1'b0);
                @(posedge clk); #1;
            end
            check_val("ready_back", rdy_s, 1'b1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_ready_a", rdy_a, 1'b1);
        check_val("rst_valid_a", rv_a, 1'b0);
        check_val("rst_rdata_a", rd_a, 8'd0);
        check_val("rst_err_a", err_a, 1'b0);
        check_val("rst_ready_b", rdy_b, 1'b1);
        check_val("rst_valid_b", rv_b, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Direct burst, back to back
        sel = 1'b0;
        for (int i = 0; i < 16; i++) send(1'b1, 1'b0, 13'(i), 8'(8'hA0 + i));
        for (int i = 0; i < 16; i++) send(1'b0, 1'b0, 13'(i), 8'h00);
        send(1'b1, 1'b0, 13'h1FFF, 8'h3C);
        send(1'b0, 1'b0, 13'h1FFF, 8'h00);

        // Indirect read
        send(1'b1, 1'b0, 13'h0020, 8'h34);
        send(1'b1, 1'b0, 13'h0021, 8'h12);
        send(1'b1, 1'b0, 13'h1234, 8'h5A);
        send(1'b0, 1'b1, 13'h0020, 8'h00);

        // Indirect write with high pointer bits masked off
        send(1'b1, 1'b0, 13'h0030, 8'h00);
        send(1'b1, 1'b0, 13'h0031, 8'hE1);
        send(1'b1, 1'b1, 13'h0030, 8'h77);
        send(1'b0, 1'b0, 13'h0100, 8'h00);
        send(1'b0, 1'b0, 13'h0030, 8'h00);
        send(1'b0, 1'b0, 13'h0031, 8'h00);

        // Indirect write onto its own pointer word
        send(1'b1, 1'b0, 13'h0040, 8'h40);
        send(1'b1, 1'b0, 13'h0041, 8'h00);
        send(1'b1, 1'b1, 13'h0040, 8'h99);
        send(1'b0, 1'b0, 13'h0040, 8'h00);
        send(1'b0, 1'b0, 13'h0041, 8'h00);

        // Errors and base wrap on the DEPTH=4096 instance
        sel = 1'b1;
        send(1'b1, 1'b0, 13'h0FFF, 8'h34);
        send(1'b1, 1'b0, 13'h0000, 8'h02);
        send(1'b1, 1'b0, 13'h0234, 8'hC3);
        send(1'b0, 1'b0, 13'h1800, 8'h00);
        send(1'b0, 1'b1, 13'h0FFF, 8'h00);
        send(1'b0, 1'b1, 13'h1FFF, 8'h00);
        send(1'b1, 1'b0, 13'h1FFF, 8'hEE);
        send(1'b0, 1'b0, 13'h0FFF, 8'h00);
        send(1'b1, 1'b0, 13'h0050, 8'h00);
        send(1'b1, 1'b0, 13'h0051, 8'h10);
        send(1'b0, 1'b1, 13'h0050, 8'h00);
        send(1'b1, 1'b1, 13'h0050, 8'hAB);
        send(1'b0, 1'b0, 13'h0000, 8'h00);

        // Reset in the middle of an indirect write
        sel = 1'b0;
        send(1'b1, 1'b0, 13'h0060, 8'h00);
        send(1'b1, 1'b0, 13'h0061, 8'h02);
        send(1'b1, 1'b0, 13'h0200, 8'h11);
        req_we = 1'b1; req_indirect = 1'b1; req_addr = 13'h0060; req_wdata = 8'h22;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_val("ptr_busy", rdy_a, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_val("midrst_ready", rdy_a, 1'b1);
        check_val("midrst_valid", rv_a, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_val("post_rst_ready", rdy_a, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        send(1'b0, 1'b0, 13'h0200, 8'h00);

        repeat (5) @(posedge clk);
        check_val("pending_a", q_a.size(), 0);
        check_val("pending_b", q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
